ser2par_pack: RTL and testbench

Serial-to-parallel line packer for the feature-map datapath. It accepts a stream of `DWI`-bit beats over a valid/ready handshake and assembles `DWO/DWI` consecutive beats into one `DWO`-bit word. It presents that word on a second valid/ready port, typically to the `par2ser` write side or to line storage. A one-word output buffer sits behind the assembly register, so input can keep streaming while the consumer stalls.

---
 rtl/acc_pkg.sv | 11 +
 rtl/ser2par_outbuf.sv | 33 +++
 rtl/ser2par_pack.sv | 86 ++++++++
 tb/tb_ser2par_pack.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// acc_pkg: shared widths, beat index type and packer state encoding for the feature-map datapath
package acc_pkg;
    localparam int ACC_BEAT_W = 32;
    localparam int ACC_LINE_W = 224;
    localparam int ACC_BEATS  = ACC_LINE_W / ACC_BEAT_W;
    typedef logic [$clog2(ACC_BEATS + 1) - 1:0] beat_idx_t;
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } ser2par_state_t;
endpackage

// File: rtl/ser2par_outbuf.sv
// ser2par_outbuf: single-entry output register with valid/ready (load, hold, drain)
// Ports: load_i/data_i/cnt_i write the entry; ready_i drains it; valid_o/data_o/cnt_o
// present it; free_o is high when the entry is empty or draining this cycle.
module ser2par_outbuf #(
    parameter int DW = 224,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic [CW-1:0] cnt_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic [CW-1:0] cnt_o,
    output logic          free_o
);
    assign free_o = !valid_o || ready_i;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            cnt_o   <= '0;
        end else if (load_i) begin
            valid_o <= 1'b1;
            data_o  <= data_i;
            cnt_o   <= cnt_i;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end
endmodule

// File: rtl/ser2par_pack.sv
// ser2par_pack: packs BEATS consecutive DWI-bit beats into one DWO-bit word, first beat in the LSBs
// Ports: in_valid/in_ready/in_data/in_last input stream; out_valid/out_ready/out_data/out_cnt
// output stream, out_cnt = valid beats in out_data. Macro SER2PAR_FLUSH_EN lets in_last close a
// word early (zero-padded); without it in_last is ignored and words are always BEATS beats.
module ser2par_pack
    import acc_pkg::*;
#(
    parameter int  DWI   = ACC_BEAT_W,
    parameter int  DWO   = ACC_LINE_W,
    localparam int BEATS = DWO / DWI,
    localparam int CW    = $clog2(BEATS + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DWI-1:0] in_data,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DWO-1:0] out_data,
    output logic [CW-1:0]  out_cnt
);
    if (DWO % DWI != 0) begin : g_bad_width
        $error("ser2par_pack: DWO must be a multiple of DWI");
    end
    ser2par_state_t state_q;
    logic [CW-1:0]  cnt_q;
    logic [DWO-1:0] asm_q;
    logic [DWO-1:0] asm_ins;
    logic [DWO-1:0] load_data;
    logic [CW-1:0]  cnt_inc;
    logic [CW-1:0]  load_cnt;
    logic           in_fire;
    logic           last_beat;
    logic           close;
    logic           slot_free;
    logic           load;
    assign in_ready  = (state_q == FILL);
    assign in_fire   = in_valid && in_ready;
    assign cnt_inc   = cnt_q + CW'(1);
    assign last_beat = (cnt_q == CW'(BEATS - 1));
    // asm is cleared whenever a word leaves, so OR-ing the beat in is enough
    assign asm_ins   = asm_q | (DWO'(in_data) << (cnt_q * DWI));
`ifdef SER2PAR_FLUSH_EN
    assign close = in_fire && (last_beat || in_last);
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign close = in_fire && last_beat;
`endif
    // HOLD drains the parked word as soon as the slot frees; FILL bypasses asm on a close
    assign load      = (state_q == HOLD) ? slot_free : (close && slot_free);
    assign load_data = (state_q == HOLD) ? asm_q : asm_ins;
    assign load_cnt  = (state_q == HOLD) ? cnt_q : cnt_inc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            asm_q   <= '0;
        end else if (load) begin
            state_q <= FILL;
            cnt_q   <= '0;
            asm_q   <= '0;
        end else if (in_fire) begin
            state_q <= close ? HOLD : FILL;
            cnt_q   <= cnt_inc;
            asm_q   <= asm_ins;
        end
    end
    ser2par_outbuf #(
        .DW(DWO),
        .CW(CW)
    ) u_outbuf (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .data_i (load_data),
        .cnt_i  (load_cnt),
        .ready_i(out_ready),
        .valid_o(out_valid),
        .data_o (out_data),
        .cnt_o  (out_cnt),
        .free_o (slot_free)
    );
endmodule

// File: tb/tb_ser2par_pack.sv
// tb_ser2par_pack: directed and random checks of ser2par_pack against a beat-queue word model
module tb_ser2par_pack;
    localparam int DWI   = 32;
    localparam int DWO   = 224;
    localparam int BEATS = DWO / DWI;
    localparam int CW    = $clog2(BEATS + 1);
`ifdef SER2PAR_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_last = 1'b0;
    logic           out_ready = 1'b0;
    logic [DWI-1:0] in_data = '0;
    logic           in_ready;
    logic           out_valid;
    logic [DWO-1:0] out_data;
    logic [CW-1:0]  out_cnt;
    int checks = 0;
    int errors = 0;
    logic [DWO-1:0] m_acc = '0;
    int             m_n = 0;
    logic [DWO-1:0] exp_d[$];
    int             exp_c[$];
    int             words_out = 0;
    int             beats_in = 0;
    logic           prev_stall = 1'b0;
    logic [DWO-1:0] prev_d = '0;
    logic [CW-1:0]  prev_c = '0;
    always #5 clk = ~clk;
    ser2par_pack dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_cnt  (out_cnt)
    );
    task automatic chk(input string name, input logic [DWO-1:0] act, input logic [DWO-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask
    // Model: collect accepted beats; a word exists once BEATS beats (or a flushed line end) arrive
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_d.delete();
            exp_c.delete();
            m_acc = '0;
            m_n = 0;
            prev_stall = 1'b0;
            chk("valid_in_reset", DWO'(out_valid), DWO'(0));
        end else begin
            if (prev_stall && out_valid) begin
                chk("stall_data", out_data, prev_d);
                chk("stall_cnt", DWO'(out_cnt), DWO'(prev_c));
            end
            if (!in_ready) chk("hold_implies_valid", DWO'(out_valid), DWO'(1));
            if (out_valid && out_ready) begin
                words_out++;
                if (exp_d.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_word: got %h expected no word", out_data);
                end else begin
                    chk("word_data", out_data, exp_d.pop_front());
                    chk("word_cnt", DWO'(out_cnt), DWO'(exp_c.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                beats_in++;
                m_acc[m_n*DWI +: DWI] = in_data;
                m_n++;
                if (m_n == BEATS || (FLUSH && in_last)) begin
                    exp_d.push_back(m_acc);
                    exp_c.push_back(m_n);
                    m_acc = '0;
                    m_n = 0;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_c = out_cnt;
        end
    end
    // Called at posedge+1; returns at posedge+1 of the accepting edge
    task automatic send(input logic [DWI-1:0] d, input logic l, output int stalls);
        int  n;
        logic acc;
        n = 0;
        stalls = 0;
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) stalls++;
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 for %0d cycles expected acceptance", n);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask
    initial begin
        int st;
        int stalls;
        int w0;
        int b0;
        int cyc;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", DWO'(in_ready), DWO'(1));
        chk("rst_out_valid", DWO'(out_valid), DWO'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_out_cnt", DWO'(out_cnt), DWO'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            send(DWI'(32'h11111111 * k), 1'b0, st);
            if (k == 6) chk("no_word_before_beat7", DWO'(out_valid), DWO'(0));
        end
        chk("seq7_valid", DWO'(out_valid), DWO'(1));
        chk("seq7_data", out_data,
            224'h77777777_66666666_55555555_44444444_33333333_22222222_11111111);
        chk("seq7_cnt", DWO'(out_cnt), DWO'(7));
        @(posedge clk);
        #1;
        w0 = words_out;
        stalls = 0;
        for (int i = 0; i < 21; i++) begin
            send(DWI'($urandom), 1'b0, st);
            stalls += st;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_words", DWO'(words_out - w0), DWO'(3));
        chk("b2b_no_stall", DWO'(stalls), DWO'(0));
        out_ready = 1'b0;
        for (int i = 0; i < 14; i++) send(DWI'(32'h100 + i), 1'b0, st);
        chk("hold_in_ready", DWO'(in_ready), DWO'(0));
        chk("hold_out_valid", DWO'(out_valid), DWO'(1));
        chk("hold_word1", DWO'(out_data[DWI-1:0]), DWO'(32'h100));
        repeat (3) @(posedge clk);
        #1;
        chk("hold_stays", DWO'(in_ready), DWO'(0));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drain_in_ready", DWO'(in_ready), DWO'(1));
        chk("drain_valid", DWO'(out_valid), DWO'(1));
        chk("drain_word2", DWO'(out_data[DWI-1:0]), DWO'(32'h107));
        @(posedge clk);
        #1;
        chk("drain_empty", DWO'(out_valid), DWO'(0));
        send(DWI'(32'hA), 1'b0, st);
        send(DWI'(32'hB), 1'b0, st);
        send(DWI'(32'hC), 1'b1, st);
`ifdef SER2PAR_FLUSH_EN
        chk("flush_valid", DWO'(out_valid), DWO'(1));
        chk("flush_cnt", DWO'(out_cnt), DWO'(3));
        chk("flush_data", out_data, 224'h0000000C_0000000B_0000000A);
        @(posedge clk);
        #1;
`else
        repeat (3) begin
            chk("noflush_no_word", DWO'(out_valid), DWO'(0));
            @(posedge clk);
            #1;
        end
`endif
        for (int i = 0; i < 4; i++) send(DWI'(32'hDEAD0000 + i), 1'b0, st);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_in_ready", DWO'(in_ready), DWO'(1));
        rst_n = 1'b1;
        w0 = words_out;
        for (int i = 0; i < 7; i++) send(DWI'(32'hF0 + i), 1'b0, st);
        chk("fresh_valid", DWO'(out_valid), DWO'(1));
        chk("fresh_first", DWO'(out_data[DWI-1:0]), DWO'(32'hF0));
        chk("fresh_cnt", DWO'(out_cnt), DWO'(7));
        @(posedge clk);
        #1;
        chk("fresh_one_word", DWO'(words_out - w0), DWO'(1));
        b0 = beats_in;
        cyc = 0;
        while (beats_in - b0 < 10000 && cyc < 60000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = DWI'($urandom);
            in_last = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        chk("rand_budget", DWO'(beats_in - b0 >= 10000), DWO'(1));
        out_ready = 1'b1;
        cyc = 0;
        while (exp_d.size() != 0 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        @(posedge clk);
        #1;
        chk("rand_drained", DWO'(exp_d.size()), DWO'(0));
        chk("rand_idle", DWO'(out_valid), DWO'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
